// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter with round-robin grant held per CYC
// and a stall watchdog that answers hung strobes with ERR.
module wb_arbiter_2m #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,

    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              abort_q, abort_d;

    logic                    own0, own1;
    logic [ADDR_WIDTH-1:0]   own_adr;
    logic [DATA_WIDTH-1:0]   own_dat;
    logic                    own_we;
    logic [SELECT_WIDTH-1:0] own_sel;
    logic                    own_stb;
    logic                    own_cyc;
    logic                    stalled;
    logic                    wd_err;
    logic                    rsp_ack;
    logic                    rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            wd_cnt_q     <= '0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            wd_cnt_q     <= wd_cnt_d;
            abort_q      <= abort_d;
        end
    end

    // Grant is only re-evaluated from IDLE, so owners are always separated
    // by one idle cycle and a held CYC can never be pre-empted.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (wbm0_cyc_i && wbm1_cyc_i) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (wbm0_cyc_i) begin
                    state_d = OWN0;
                end else if (wbm1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!wbm0_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            OWN1: begin
                if (!wbm1_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign grant_o = {own1, own0};

    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_we  = 1'b0;
        own_sel = '0;
        own_stb = 1'b0;
        own_cyc = 1'b0;
        if (own0) begin
            own_adr = wbm0_adr_i;
            own_dat = wbm0_dat_i;
            own_we  = wbm0_we_i;
            own_sel = wbm0_sel_i;
            own_stb = wbm0_stb_i;
            own_cyc = wbm0_cyc_i;
        end else if (own1) begin
            own_adr = wbm1_adr_i;
            own_dat = wbm1_dat_i;
            own_we  = wbm1_we_i;
            own_sel = wbm1_sel_i;
            own_stb = wbm1_stb_i;
            own_cyc = wbm1_cyc_i;
        end
    end

    assign wbs_adr_o = own_adr;
    assign wbs_dat_o = own_dat;
    assign wbs_we_o  = own_we;
    assign wbs_sel_o = own_sel;
    assign wbs_cyc_o = own_cyc;
    assign wbs_stb_o = own_stb & ~abort_q;

    assign stalled = wbs_stb_o & ~wbs_ack_i & ~wbs_err_i;
    assign wd_err  = WD_EN && stalled && (wd_cnt_q == WD_LAST);

    // After a watchdog ERR the strobe stays masked until the owner withdraws
    // it, so a slave that wakes up late cannot complete a beat already failed.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        abort_d  = abort_q;
        if (!WD_EN || !stalled || wd_err || (state_d != state_q)) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if ((state_d != state_q) || !own_stb) begin
            abort_d = 1'b0;
        end else if (wd_err) begin
            abort_d = 1'b1;
        end
    end

    assign rsp_ack   = wbs_ack_i & ~wbs_err_i & ~abort_q;
    assign rsp_err   = (wbs_err_i & ~abort_q) | wd_err;
    assign timeout_o = wd_err;

    assign wbm0_ack_o = own0 & rsp_ack;
    assign wbm0_err_o = own0 & rsp_err;
    assign wbm0_dat_o = own0 ? wbs_dat_i : '0;
    assign wbm1_ack_o = own1 & rsp_ack;
    assign wbm1_err_o = own1 & rsp_err;
    assign wbm1_dat_o = own1 ? wbs_dat_i : '0;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: watchdog instance (TIMEOUT=8) plus a
// TIMEOUT=0 instance sharing the same stimulus.
module tb_wb_arbiter_2m;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_wdat, m1_wdat;
    logic          m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic [SW-1:0] m0_sel, m1_sel;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_err;

    logic [DW-1:0] m0_rdat, m1_rdat, s_wdat;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [AW-1:0] s_adr;
    logic          s_we, s_stb, s_cyc, tmo;
    logic [SW-1:0] s_sel;
    logic [1:0]    grant;

    logic [DW-1:0] nw_m0_rdat, nw_m1_rdat, nw_s_wdat;
    logic          nw_m0_ack, nw_m0_err, nw_m1_ack, nw_m1_err;
    logic [AW-1:0] nw_s_adr;
    logic          nw_s_we, nw_s_stb, nw_s_cyc, nw_tmo;
    logic [SW-1:0] nw_s_sel;
    logic [1:0]    nw_grant;

    wb_arbiter_2m #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_wdat), .wbm0_dat_o(m0_rdat),
        .wbm0_we_i(m0_we), .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb),
        .wbm0_cyc_i(m0_cyc), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err),
        .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_wdat), .wbm1_dat_o(m1_rdat),
        .wbm1_we_i(m1_we), .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb),
        .wbm1_cyc_i(m1_cyc), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_dat_i(s_rdat),
        .wbs_we_o(s_we), .wbs_sel_o(s_sel), .wbs_stb_o(s_stb),
        .wbs_cyc_o(s_cyc), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .grant_o(grant), .timeout_o(tmo)
    );

    wb_arbiter_2m #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(0)) dut_nw (
        .clk(clk), .rst(rst),
        .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_wdat), .wbm0_dat_o(nw_m0_rdat),
        .wbm0_we_i(m0_we), .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb),
        .wbm0_cyc_i(m0_cyc), .wbm0_ack_o(nw_m0_ack), .wbm0_err_o(nw_m0_err),
        .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_wdat), .wbm1_dat_o(nw_m1_rdat),
        .wbm1_we_i(m1_we), .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb),
        .wbm1_cyc_i(m1_cyc), .wbm1_ack_o(nw_m1_ack), .wbm1_err_o(nw_m1_err),
        .wbs_adr_o(nw_s_adr), .wbs_dat_o(nw_s_wdat), .wbs_dat_i(s_rdat),
        .wbs_we_o(nw_s_we), .wbs_sel_o(nw_s_sel), .wbs_stb_o(nw_s_stb),
        .wbs_cyc_o(nw_s_cyc), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .grant_o(nw_grant), .timeout_o(nw_tmo)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int            m;
        logic          err;
        logic [DW-1:0] dat;
    } rsp_t;
    rsp_t sb_q[$];
    logic mon_en = 1'b1;

    task automatic sb_push(input int m, input logic err, input logic [DW-1:0] dat);
        rsp_t r;
        r.m = m; r.err = err; r.dat = dat;
        sb_q.push_back(r);
    endtask

    task automatic sb_pop(input int m, input logic a, input logic e, input logic [DW-1:0] d);
        rsp_t r;
        if (sb_q.size() == 0) begin
            chk($sformatf("sb_unexpected_rsp_m%0d", m), 64'(sb_q.size()), 64'd1);
        end else begin
            r = sb_q.pop_front();
            chk("sb_master", 64'(m), 64'(r.m));
            chk("sb_err", 64'(e), 64'(r.err));
            chk("sb_ack", 64'(a), 64'(!r.err));
            if (!r.err) chk("sb_dat", 64'(d), 64'(r.dat));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (m0_ack || m0_err) sb_pop(0, m0_ack, m0_err, m0_rdat);
            if (m1_ack || m1_err) sb_pop(1, m1_ack, m1_err, m1_rdat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench timed out");
    end

    int nw_errs, nw_tos, main_tos;

    initial begin
        m0_adr = '0; m0_wdat = '0; m0_we = 0; m0_sel = '0; m0_stb = 0; m0_cyc = 0;
        m1_adr = '0; m1_wdat = '0; m1_we = 0; m1_sel = '0; m1_stb = 0; m1_cyc = 0;
        s_rdat = 32'hDEAD_BEEF; s_ack = 0; s_err = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_wbs_cyc", 64'(s_cyc), 64'd0);
        chk("rst_wbs_stb", 64'(s_stb), 64'd0);
        chk("rst_wbs_adr", 64'(s_adr), 64'd0);
        chk("rst_timeout", 64'(tmo), 64'd0);
        chk("rst_m0_dat", 64'(m0_rdat), 64'd0);

        // Single master write, slave acks on second owned cycle
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h10; m0_wdat = 32'hA5A5_0001; m0_sel = 4'hF;
        @(negedge clk);
        chk("w_pre_grant", 64'(grant), 64'd0);
        chk("w_pre_cyc", 64'(s_cyc), 64'd0);
        tick();
        @(negedge clk);
        chk("w_grant", 64'(grant), 64'd1);
        chk("w_adr", 64'(s_adr), 64'h10);
        chk("w_wdat", 64'(s_wdat), 64'hA5A5_0001);
        chk("w_we", 64'(s_we), 64'd1);
        chk("w_stb", 64'(s_stb), 64'd1);
        chk("w_m1_dat_gated", 64'(m1_rdat), 64'd0);
        tick();
        s_ack = 1; sb_push(0, 0, s_rdat);
        @(negedge clk);
        chk("w_m1_ack", 64'(m1_ack), 64'd0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        @(negedge clk);
        chk("w_cyc_drop", 64'(s_cyc), 64'd0);
        tick();
        @(negedge clk);
        chk("w_idle", 64'(grant), 64'd0);

        // Tie after reset goes to master 0, then master 1, one idle between
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        @(negedge clk);
        chk("arb_pre", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        chk("arb_first", 64'(grant), 64'd1);
        tick();
        m0_cyc = 0;
        @(negedge clk);
        chk("arb_hold_last", 64'(grant), 64'd1);
        tick();
        @(negedge clk);
        chk("arb_gap", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        chk("arb_second", 64'(grant), 64'd2);
        tick();
        m1_cyc = 0;
        @(negedge clk);
        chk("arb_second_hold", 64'(grant), 64'd2);
        tick();
        m0_cyc = 1; m1_cyc = 1;
        @(negedge clk);
        chk("arb_gap2", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        chk("arb_alt0", 64'(grant), 64'd1);
        tick();
        m0_cyc = 0; m1_cyc = 0;
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        @(negedge clk);
        chk("arb_tie_m1", 64'(grant), 64'd2);
        tick();
        m0_cyc = 0; m1_cyc = 0;
        repeat (2) tick();

        // Hold: master 0 does 3 beats while master 1 waits
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h20;
        tick();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h40;
        for (int b = 0; b < 3; b++) begin
            s_ack = 1; s_rdat = 32'h1234_0000 + 32'(b); sb_push(0, 0, s_rdat);
            @(negedge clk);
            chk($sformatf("hold_grant_b%0d", b), 64'(grant), 64'd1);
            chk($sformatf("hold_adr_b%0d", b), 64'(s_adr), 64'h20);
            tick();
        end
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        chk("hold_end", 64'(grant), 64'd1);
        tick();
        @(negedge clk);
        chk("hold_gap", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        chk("hold_m1", 64'(grant), 64'd2);
        chk("hold_m1_adr", 64'(s_adr), 64'h40);
        tick();
        s_ack = 1; s_rdat = 32'hCAFE_0001; sb_push(1, 0, s_rdat);
        @(negedge clk);
        chk("hold_m0_dat_gated", 64'(m0_rdat), 64'd0);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        repeat (2) tick();

        // Watchdog: no response, ERR on the 8th stalled strobe cycle
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h80;
        tick();
        for (int c = 1; c <= 11; c++) begin
            if (c == 8) sb_push(0, 1, '0);
            @(negedge clk);
            chk($sformatf("wd_pulse_c%0d", c), 64'(tmo), 64'(c == 8));
            chk($sformatf("wd_stb_c%0d", c), 64'(s_stb), 64'(c <= 8));
            tick();
        end
        s_ack = 1;
        @(negedge clk);
        chk("wd_late_ack", 64'(m0_ack), 64'd0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        @(negedge clk);
        chk("wd_quiet", 64'(tmo), 64'd0);
        tick();

        // Slave ack+err together: err wins; plain slave err routed to m1
        m0_cyc = 1; m0_stb = 1;
        tick();
        s_ack = 1; s_err = 1; sb_push(0, 1, '0);
        @(negedge clk);
        tick();
        s_ack = 0; s_err = 0; m0_cyc = 0; m0_stb = 0;
        repeat (2) tick();
        m1_cyc = 1; m1_stb = 1;
        tick();
        s_err = 1; sb_push(1, 1, '0);
        @(negedge clk);
        tick();
        s_err = 0; m1_cyc = 0; m1_stb = 0;
        repeat (2) tick();

        // TIMEOUT=0 never fires; the TIMEOUT=8 instance fires once then aborts
        mon_en = 0;
        nw_errs = 0; nw_tos = 0; main_tos = 0;
        m0_cyc = 1; m0_stb = 1;
        tick();
        repeat (1000) begin
            @(negedge clk);
            if (nw_m0_err || nw_m1_err) nw_errs++;
            if (nw_tmo) nw_tos++;
            if (tmo) main_tos++;
            tick();
        end
        chk("nowd_err", 64'(nw_errs), 64'd0);
        chk("nowd_timeout", 64'(nw_tos), 64'd0);
        chk("wd_single_fire", 64'(main_tos), 64'd1);
        m0_cyc = 0; m0_stb = 0;
        repeat (2) tick();
        mon_en = 1;

        // Asynchronous reset mid-transfer
        m0_cyc = 1; m0_stb = 1;
        tick();
        @(negedge clk);
        chk("rst_mid_owned", 64'(grant), 64'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_grant", 64'(grant), 64'd0);
        chk("rst_async_cyc", 64'(s_cyc), 64'd0);
        chk("rst_async_stb", 64'(s_stb), 64'd0);
        repeat (2) tick();
        rst = 1'b0; m1_cyc = 1;
        @(negedge clk);
        chk("rst_post_idle", 64'(grant), 64'd0);
        tick();
        @(negedge clk);
        chk("rst_post_tie", 64'(grant), 64'd1);
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0;
        repeat (3) tick();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master, one-slave Wishbone arbiter that shares the single master port of the address-decoding mux between two requesters (e.g. SPI-to-Wishbone bridge and soft CPU). Round-robin grant is held for a whole cycle (CYC high). A bus watchdog terminates hung transfers with ERR so that an absent or unmapped slave cannot lock the bus.

Parameters:
DATA_WIDTH, 32, data bus width in bits (8/16/32/64)
ADDR_WIDTH, 32, address bus width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT, 255, stb-without-ack cycles before watchdog ERR; 0 disables watchdog

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
wbm0_adr_i / wbm1_adr_i  input  ADDR_WIDTH  master address
wbm0_dat_i / wbm1_dat_i  input  DATA_WIDTH  master write data
wbm0_dat_o / wbm1_dat_o  output  DATA_WIDTH  read data to master
wbm0_we_i / wbm1_we_i  input  1  write enable
wbm0_sel_i / wbm1_sel_i  input  SELECT_WIDTH  byte select
wbm0_stb_i / wbm1_stb_i  input  1  strobe
wbm0_cyc_i / wbm1_cyc_i  input  1  cycle request
wbm0_ack_o / wbm1_ack_o  output  1  acknowledge
wbm0_err_o / wbm1_err_o  output  1  error (slave error or watchdog)
wbs_adr_o  output  ADDR_WIDTH  address to slave/mux
wbs_dat_o  output  DATA_WIDTH  write data to slave
wbs_dat_i  input  DATA_WIDTH  read data from slave
wbs_we_o  output  1  write enable
wbs_sel_o  output  SELECT_WIDTH  byte select
wbs_stb_o  output  1  strobe
wbs_cyc_o  output  1  cycle
wbs_ack_i  input  1  slave acknowledge
wbs_err_i  input  1  slave error
grant_o  output  2  one-hot current owner (bit0 = master 0), 00 when idle
timeout_o  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: state IDLE, grant_o=00, last_owner=1 (so master 0 wins the first tie), watchdog count=0, timeout_o=0. All wbs_* and wbm*_ack/err outputs are 0; dat outputs are 0 via the grant gating.
- States: IDLE, OWN0, OWN1. Grant is registered.
- IDLE: only cyc0 -> OWN0; only cyc1 -> OWN1; both -> the master that is not last_owner. Latency: cyc_i rising -> wbs_cyc_o high on the next clock edge.
- OWNn: held while wbmn_cyc_i=1. When wbmn_cyc_i=0, go to IDLE and set last_owner=n. There is always one IDLE cycle between owners. The other master's request is never served mid-cycle.
- Datapath (combinational from the registered grant):
  - wbs_adr/dat/we/sel driven from the owner.
  - wbs_cyc_o = owner cyc. wbs_stb_o = owner stb & ~abort.
  - Owner gets ack = wbs_ack_i & ~wbs_err_i and err = wbs_err_i | wd_err. If ack and err arrive together, err wins.
  - Owner dat_o = wbs_dat_i. Non-owner ack/err = 0 and dat_o = 0.
  - In IDLE all wbs_* outputs are 0.
- Watchdog:
  - Count increments each cycle that wbs_stb_o=1 and wbs_ack_i=wbs_err_i=0. It clears on ack, err, stb low or a state change.
  - When count reaches TIMEOUT-1 with no response: wd_err=1 to the owner for that cycle, timeout_o=1, count clears.
  - abort is held until the owner drops stb, so a late slave ack is never forwarded.
  - Counter width is clog2(TIMEOUT+1). TIMEOUT=0 means the watchdog never fires.
- Pipelined/back-to-back: the owner may issue multiple stb beats within one cyc. The grant is kept throughout.
- Async reset mid-transfer: all outputs drop immediately and the in-flight transfer is lost. Masters must restart after reset.

Test Plan:
- Single master: wbm0 write adr=0x10, dat=0xA5A5_0001, slave acks on the 2nd cycle -> grant_o=01 one cycle after cyc; wbs_adr_o=0x10; wbm0_ack_o high one cycle; wbm1_ack_o stays 0.
- Simultaneous requests after reset -> master 0 is granted first; after its cyc drops, 1 IDLE cycle, then grant_o=10. Repeat with simultaneous requests -> master 0 granted again (alternation).
- Hold: master 1 raises cyc while master 0 does 3 back-to-back beats -> grant_o stays 01 for all 3 acks; master 1 is granted only after wbm0_cyc_i falls.
- Watchdog: TIMEOUT=8, slave never acks -> wbm0_err_o and timeout_o pulse exactly 8 cycles after stb; wbs_stb_o low until the master drops stb; a late ack is not forwarded.
- Slave ack and err in the same cycle -> owner sees err=1, ack=0. With TIMEOUT=0 and no ack for 1000 cycles -> no err.
- Assert rst mid-transfer -> grant_o=00, wbs_cyc_o=0 asynchronously. After release, a tie is granted to master 0.
